// File: rtl/issue_unit.sv
// issue_unit: single-issue arbiter between the int, load/store, multiply and
// divide issue queues. Grants at most one queue per cycle and reserves the
// CDB cycle in which that unit's fixed-latency result will broadcast, so no
// two units ever drive the CDB together. Also tracks the non-pipelined divider.
module issue_unit #(
    parameter int INT_LAT = 1,
    parameter int LS_LAT  = 2,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 7,
    parameter int MAX_LAT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iq_int_rdy,
    input  logic       iq_ls_rdy,
    input  logic       iq_mul_rdy,
    input  logic       iq_div_rdy,
    input  logic       cdb_flush,
    output logic       iu_int_r_en,
    output logic       iu_ls_r_en,
    output logic       iu_mul_r_en,
    output logic       iu_div_r_en,
    output logic [0:1] iu_cdb_sel,
    output logic       iu_cdb_sel_valid,
    output logic       iu_div_busy
);

    localparam int CNT_W = $clog2(DIV_LAT + 1);

    localparam logic [1:0] OWN_INT = 2'd0;
    localparam logic [1:0] OWN_LS  = 2'd1;
    localparam logic [1:0] OWN_MUL = 2'd2;
    localparam logic [1:0] OWN_DIV = 2'd3;

    // slot k describes the CDB k cycles from now
    logic [MAX_LAT-1:0] slot_valid;
    logic [1:0]         slot_owner [MAX_LAT];
    logic [CNT_W-1:0]   div_cnt;
    logic               lru;

    // One extra always-free entry so a latency equal to MAX_LAT indexes safely
    logic [MAX_LAT:0]   valid_ext;

    logic int_elig;
    logic ls_elig;
    logic mul_elig;
    logic div_elig;
    logic grant_int;
    logic grant_ls;
    logic grant_mul;
    logic grant_div;
    logic issue_ok;

    assign valid_ext = {1'b0, slot_valid};

    // Per-unit eligibility: queue ready, target CDB cycle free, no flush, not in reset
    always_comb begin
        issue_ok = !reset && !cdb_flush;
        int_elig = issue_ok && iq_int_rdy && !valid_ext[INT_LAT];
        ls_elig  = issue_ok && iq_ls_rdy  && !valid_ext[LS_LAT];
        mul_elig = issue_ok && iq_mul_rdy && !valid_ext[MUL_LAT];
        div_elig = issue_ok && iq_div_rdy && !valid_ext[DIV_LAT] && (div_cnt == '0);
    end

    // Fixed priority div > mul, then int/ls by LRU; the unfavoured one wins if the favoured is blocked
    always_comb begin
        grant_int = 1'b0;
        grant_ls  = 1'b0;
        grant_mul = 1'b0;
        grant_div = 1'b0;
        if (div_elig) begin
            grant_div = 1'b1;
        end else if (mul_elig) begin
            grant_mul = 1'b1;
        end else if (lru) begin
            if (ls_elig) begin
                grant_ls = 1'b1;
            end else if (int_elig) begin
                grant_int = 1'b1;
            end
        end else begin
            if (int_elig) begin
                grant_int = 1'b1;
            end else if (ls_elig) begin
                grant_ls = 1'b1;
            end
        end
    end

    assign iu_int_r_en = grant_int;
    assign iu_ls_r_en  = grant_ls;
    assign iu_mul_r_en = grant_mul;
    assign iu_div_r_en = grant_div;

    // Reservation vector: shift one cycle closer, then book the granted unit's CDB cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_valid <= '0;
            for (int k = 0; k < MAX_LAT; k++) begin
                slot_owner[k] <= OWN_INT;
            end
        end else begin
            for (int k = 0; k < MAX_LAT - 1; k++) begin
                slot_valid[k] <= slot_valid[k+1];
                slot_owner[k] <= slot_owner[k+1];
            end
            slot_valid[MAX_LAT-1] <= 1'b0;
            slot_owner[MAX_LAT-1] <= OWN_INT;
            // Eligibility already guaranteed these entries are free after the shift
            if (grant_int) begin
                slot_valid[INT_LAT-1] <= 1'b1;
                slot_owner[INT_LAT-1] <= OWN_INT;
            end
            if (grant_ls) begin
                slot_valid[LS_LAT-1] <= 1'b1;
                slot_owner[LS_LAT-1] <= OWN_LS;
            end
            if (grant_mul) begin
                slot_valid[MUL_LAT-1] <= 1'b1;
                slot_owner[MUL_LAT-1] <= OWN_MUL;
            end
            if (grant_div) begin
                slot_valid[DIV_LAT-1] <= 1'b1;
                slot_owner[DIV_LAT-1] <= OWN_DIV;
            end
        end
    end

    // Divider occupancy: load on grant, count down to idle; flush does not cancel it
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (grant_div) begin
            div_cnt <= CNT_W'(DIV_LAT);
        end else if (div_cnt != '0) begin
            div_cnt <= div_cnt - CNT_W'(1);
        end
    end

    // int/ls LRU: point at the one not just served; mul/div grants leave it alone
    always_ff @(posedge clk) begin
        if (reset) begin
            lru <= 1'b0;
        end else if (grant_int) begin
            lru <= 1'b1;
        end else if (grant_ls) begin
            lru <= 1'b0;
        end
    end

    assign iu_cdb_sel_valid = slot_valid[0];
    assign iu_cdb_sel       = slot_owner[0];
    assign iu_div_busy      = (div_cnt != '0);

endmodule

// File: tb/tb_issue_unit.sv
// Directed bench for issue_unit: a cycle-by-cycle table of inputs and
// hand-computed outputs, plus a hand-written divider-occupancy sequence.
module tb_issue_unit;

    logic       clk;
    logic       reset;
    logic       iq_int_rdy;
    logic       iq_ls_rdy;
    logic       iq_mul_rdy;
    logic       iq_div_rdy;
    logic       cdb_flush;
    logic       iu_int_r_en;
    logic       iu_ls_r_en;
    logic       iu_mul_r_en;
    logic       iu_div_r_en;
    logic [0:1] iu_cdb_sel;
    logic       iu_cdb_sel_valid;
    logic       iu_div_busy;

    int n_chk  = 0;
    int n_fail = 0;

    issue_unit dut (
        .clk              (clk),
        .reset            (reset),
        .iq_int_rdy       (iq_int_rdy),
        .iq_ls_rdy        (iq_ls_rdy),
        .iq_mul_rdy       (iq_mul_rdy),
        .iq_div_rdy       (iq_div_rdy),
        .cdb_flush        (cdb_flush),
        .iu_int_r_en      (iu_int_r_en),
        .iu_ls_r_en       (iu_ls_r_en),
        .iu_mul_r_en      (iu_mul_r_en),
        .iu_div_r_en      (iu_div_r_en),
        .iu_cdb_sel       (iu_cdb_sel),
        .iu_cdb_sel_valid (iu_cdb_sel_valid),
        .iu_div_busy      (iu_div_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // rdy and ren are ordered {div, mul, ls, int}
    typedef struct {
        logic       rst;
        logic [3:0] rdy;
        logic       flush;
        logic [3:0] ren;
        logic       v;
        logic [1:0] sel;
        logic       busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [3:0] rdy, input logic flush,
                       input logic [3:0] ren, input logic v, input logic [1:0] sel,
                       input logic busy);
        vec_t e;
        e.rst = rst; e.rdy = rdy; e.flush = flush;
        e.ren = ren; e.v = v; e.sel = sel; e.busy = busy;
        vecs.push_back(e);
    endtask

    task automatic chk(input string nm, input int idx, input logic [3:0] act,
                       input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at step %0d: got %0h, expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [3:0] rdy, input logic flush);
        reset      = rst;
        iq_div_rdy = rdy[3];
        iq_mul_rdy = rdy[2];
        iq_ls_rdy  = rdy[1];
        iq_int_rdy = rdy[0];
        cdb_flush  = flush;
    endtask

    function automatic logic [3:0] ren_now();
        return {iu_div_r_en, iu_mul_r_en, iu_ls_r_en, iu_int_r_en};
    endfunction

    initial begin
        // reset sequence, mid-operation reset
        add(1, 4'b1111, 0, 4'b0000, 0, 0, 0);
        add(1, 4'b1111, 0, 4'b0000, 0, 0, 0);
        add(0, 4'b1111, 0, 4'b1000, 0, 0, 0);
        add(1, 4'b0000, 0, 4'b0000, 0, 0, 1);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0);
        // int streaming
        add(0, 4'b0001, 0, 4'b0001, 0, 0, 0);
        add(0, 4'b0001, 0, 4'b0001, 1, 0, 0);
        add(0, 4'b0001, 0, 4'b0001, 1, 0, 0);
        add(0, 4'b0001, 0, 4'b0001, 1, 0, 0);
        add(0, 4'b0000, 0, 4'b0000, 1, 0, 0);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0);
        add(1, 4'b0000, 0, 4'b0000, 0, 0, 0);
        // collision avoidance: int blocked by mul's CDB cycle, ls slips in
        add(0, 4'b0100, 0, 4'b0100, 0, 0, 0);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0);
        add(0, 4'b0011, 0, 4'b0010, 0, 0, 0);
        add(0, 4'b0000, 0, 4'b0000, 1, 2, 0);
        add(0, 4'b0000, 0, 4'b0000, 1, 1, 0);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0);
        // int/ls both ready: after an ls grant, int's CDB cycle is always taken
        add(0, 4'b0011, 0, 4'b0001, 0, 0, 0);
        add(0, 4'b0011, 0, 4'b0010, 1, 0, 0);
        add(0, 4'b0011, 0, 4'b0010, 0, 0, 0);
        add(0, 4'b0011, 0, 4'b0010, 1, 1, 0);
        add(0, 4'b0000, 0, 4'b0000, 1, 1, 0);
        add(0, 4'b0000, 0, 4'b0000, 1, 1, 0);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0);
        // LRU alternation with gaps so both are eligible
        add(0, 4'b0011, 0, 4'b0001, 0, 0, 0);
        add(0, 4'b0000, 0, 4'b0000, 1, 0, 0);
        add(0, 4'b0011, 0, 4'b0010, 0, 0, 0);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0);
        add(0, 4'b0011, 0, 4'b0001, 1, 1, 0);
        add(0, 4'b0000, 0, 4'b0000, 1, 0, 0);
        // pipelined multiplier back to back
        add(1, 4'b0000, 0, 4'b0000, 0, 0, 0);
        add(0, 4'b0100, 0, 4'b0100, 0, 0, 0);
        add(0, 4'b0100, 0, 4'b0100, 0, 0, 0);
        add(0, 4'b0100, 0, 4'b0100, 0, 0, 0);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0);
        add(0, 4'b0000, 0, 4'b0000, 1, 2, 0);
        add(0, 4'b0000, 0, 4'b0000, 1, 2, 0);
        add(0, 4'b0000, 0, 4'b0000, 1, 2, 0);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 0);
        // flush suppresses grants but keeps reservations
        add(0, 4'b0100, 0, 4'b0100, 0, 0, 0);
        add(0, 4'b1111, 1, 4'b0000, 0, 0, 0);
        add(0, 4'b1111, 0, 4'b1000, 0, 0, 0);
        add(0, 4'b0000, 0, 4'b0000, 0, 0, 1);
        add(0, 4'b0000, 0, 4'b0000, 1, 2, 1);
        add(1, 4'b0000, 0, 4'b0000, 0, 0, 1);

        drive(1, 4'b0000, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("init_ren",   -1, ren_now(), 4'b0000);
        chk("init_valid", -1, {3'b0, iu_cdb_sel_valid}, 4'b0000);
        chk("init_sel",   -1, {2'b0, iu_cdb_sel}, 4'b0000);
        chk("init_busy",  -1, {3'b0, iu_div_busy}, 4'b0000);
        @(posedge clk);

        foreach (vecs[i]) begin
            #1;
            drive(vecs[i].rst, vecs[i].rdy, vecs[i].flush);
            @(negedge clk);
            chk("r_en",  i, ren_now(), vecs[i].ren);
            chk("valid", i, {3'b0, iu_cdb_sel_valid}, {3'b0, vecs[i].v});
            if (vecs[i].v) chk("sel", i, {2'b0, iu_cdb_sel}, {2'b0, vecs[i].sel});
            chk("busy",  i, {3'b0, iu_div_busy}, {3'b0, vecs[i].busy});
            @(posedge clk);
        end

        // divider occupancy: div ready throughout, flush in cycle 3 must not disturb the count
        for (int c = 0; c <= 8; c++) begin
            logic exp_grant;
            exp_grant = (c == 0) || (c == 8);
            #1;
            drive(0, 4'b1000, c == 3);
            @(negedge clk);
            chk("div_r_en",  100 + c, ren_now(), {exp_grant, 3'b000});
            chk("div_busy",  100 + c, {3'b0, iu_div_busy}, {3'b0, (c >= 1 && c <= 7)});
            chk("div_valid", 100 + c, {3'b0, iu_cdb_sel_valid}, {3'b0, (c == 7)});
            if (c == 7) chk("div_sel", 100 + c, {2'b0, iu_cdb_sel}, 4'd3);
            @(posedge clk);
        end

        #1;
        drive(0, 4'b0000, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
